// File: rtl/riscv_pkg.sv
// Shared RV64 constants, opcode encodings and the fetch-stage state type.
package riscv_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 64'd4;

   localparam logic [6:0] OpcLd  = 7'b0000011;
   localparam logic [6:0] OpcSd  = 7'b0100011;
   localparam logic [6:0] OpcBeq = 7'b1100011;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StHold,
      StHalt
   } fetch_state_e;

endpackage

// File: rtl/pc_next_gen.sv
// Combinational next-PC: sequential step or beq target (offset given in halfwords).
module pc_next_gen
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] pc_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_imm_i,
   output logic [XLEN-1:0] pc_next_o
);

   logic [XLEN-1:0] offset;

   // Wraps modulo 2^64; misaligned targets are passed through untouched.
   assign offset    = branch_taken_i ? (branch_imm_i << 1) : PC_INC;
   assign pc_next_o = pc_i + offset;

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage with a one-entry output register.
// Optional HALT_ON_ZERO_EN: an all-zero fetched word parks the stage in HALT until reset.
module instruction_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [ILEN-1:0] imem_rdata,
   output logic [ILEN-1:0] inst,
   output logic            inst_valid,
   input  logic            inst_accept,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_imm,
   output logic [XLEN-1:0] pc,
   output logic            halted
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_next;
   logic [ILEN-1:0] inst_q, inst_d;
   logic            inst_valid_q, inst_valid_d;
   logic            consume;

   pc_next_gen u_pc_next_gen (
      .pc_i           (pc_q),
      .branch_taken_i (branch_taken),
      .branch_imm_i   (branch_imm),
      .pc_next_o      (pc_next)
   );

   assign consume = inst_accept && inst_valid_q;

`ifdef HALT_ON_ZERO_EN
   logic halted_q, halted_d;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      imem_req     = 1'b0;
`ifdef HALT_ON_ZERO_EN
      halted_d     = halted_q;
`endif
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               inst_d = imem_rdata;
`ifdef HALT_ON_ZERO_EN
               if (imem_rdata == '0) begin
                  state_d  = StHalt;
                  halted_d = 1'b1;
               end else
`endif
               begin
                  inst_valid_d = 1'b1;
                  state_d      = StHold;
               end
            end
         end
         StHold: begin
            if (consume) begin
               inst_valid_d = 1'b0;
               pc_d         = pc_next;
               state_d      = StFetch;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
`ifdef HALT_ON_ZERO_EN
         halted_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
`ifdef HALT_ON_ZERO_EN
         halted_q     <= halted_d;
`endif
      end
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
`ifdef HALT_ON_ZERO_EN
   assign halted     = halted_q;
`else
   assign halted     = 1'b0;
`endif

endmodule
